// File: rtl/weight_pingpong_buf.sv
// Ping-pong weight store: a stream loader fills one bank of per-channel RAMs
// while the array reads the other bank; per-bank FULL flags hand banks over.
module weight_pingpong_buf #(
   parameter int SRAM_DEPTH = 50,
   parameter int NUM_CH     = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [$clog2(SRAM_DEPTH+1)-1:0]      cfg_depth,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [DATA_WIDTH-1:0]                s_data,
   output logic                                 fill_done,
   output logic                                 rd_avail,
   output logic                                 rd_bank,
   input  logic                                 rd_release,
   input  logic [NUM_CH-1:0]                    enb,
   input  logic [NUM_CH*$clog2(SRAM_DEPTH)-1:0] addrb,
   output logic [NUM_CH*DATA_WIDTH-1:0]         dob,
   output logic [NUM_CH-1:0]                    dob_valid,
   output logic [1:0]                           full_cnt
);
   localparam int AW  = $clog2(SRAM_DEPTH);
   localparam int CW  = $clog2(SRAM_DEPTH+1);
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CW-1:0]  DEPTH_MAX = CW'(SRAM_DEPTH);
   localparam logic [CHW-1:0] CH_LAST   = CHW'(NUM_CH - 1);

   typedef enum logic {IDLE, LOAD} state_e;

   state_e                   state_q, state_d;
   logic                     wr_bank_q, wr_bank_d;
   logic                     rd_bank_q, rd_bank_d;
   logic [1:0]               full_q, full_d;
   logic [CHW-1:0]           ch_q, ch_d;
   logic [AW-1:0]            addr_q, addr_d;
   logic [CW-1:0]            depth_q, depth_d;
   logic                     fill_done_q, fill_done_d;
   logic                     wr_en;
   logic                     addr_last;

   logic [DATA_WIDTH-1:0]                 mem_q [2][NUM_CH][SRAM_DEPTH];
   logic [NUM_CH-1:0][DATA_WIDTH-1:0]     dob_q;
   logic [NUM_CH-1:0]                     dob_valid_q;

   // Zero or oversized depth requests fall back to a full-depth fill.
   function automatic logic [CW-1:0] sat_depth(input logic [CW-1:0] d);
      if (d == '0 || d > DEPTH_MAX) return DEPTH_MAX;
      return d;
   endfunction

   assign addr_last = (CW'(addr_q) == depth_q - CW'(1));

   always_comb begin
      state_d     = state_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      full_d      = full_q;
      ch_d        = ch_q;
      addr_d      = addr_q;
      depth_d     = depth_q;
      fill_done_d = 1'b0;
      s_ready     = 1'b0;
      wr_en       = 1'b0;
      case (state_q)
         IDLE: begin
            if (!full_q[wr_bank_q]) begin
               state_d = LOAD;
               ch_d    = '0;
               addr_d  = '0;
               depth_d = sat_depth(cfg_depth);
            end
         end
         LOAD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               wr_en = 1'b1;
               if (addr_last) begin
                  addr_d = '0;
                  if (ch_q == CH_LAST) begin
                     full_d[wr_bank_q] = 1'b1;
                     wr_bank_d         = ~wr_bank_q;
                     fill_done_d       = 1'b1;
                     state_d           = IDLE;
                  end else begin
                     ch_d = ch_q + CHW'(1);
                  end
               end else begin
                  addr_d = addr_q + AW'(1);
               end
            end
         end
      endcase
      // The release always hits the read bank, never the bank being filled.
      if (rd_release && full_q[rd_bank_q]) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         full_q      <= 2'b00;
         ch_q        <= '0;
         addr_q      <= '0;
         depth_q     <= DEPTH_MAX;
         fill_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         full_q      <= full_d;
         ch_q        <= ch_d;
         addr_q      <= addr_d;
         depth_q     <= depth_d;
         fill_done_q <= fill_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_bank_q][ch_q][addr_q] <= s_data;
   end

   // Read ports: one-cycle latency, data held when not enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dob_q       <= '0;
         dob_valid_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (enb[i] && rd_avail) begin
               dob_q[i]       <= mem_q[rd_bank_q][i][addrb[i*AW +: AW]];
               dob_valid_q[i] <= 1'b1;
            end else begin
               dob_valid_q[i] <= 1'b0;
            end
         end
      end
   end

   assign fill_done = fill_done_q;
   assign rd_bank   = rd_bank_q;
   assign rd_avail  = full_q[rd_bank_q];
   assign full_cnt  = {1'b0, full_q[0]} + {1'b0, full_q[1]};
   assign dob       = dob_q;
   assign dob_valid = dob_valid_q;

endmodule

// File: tb/tb_weight_pingpong_buf.sv
// Self-checking bench for weight_pingpong_buf against a bank/beat level model.
module tb_weight_pingpong_buf;
   localparam int SRAM_DEPTH = 50;
   localparam int NUM_CH     = 16;
   localparam int DATA_WIDTH = 8;
   localparam int AW         = $clog2(SRAM_DEPTH);
   localparam int CW         = $clog2(SRAM_DEPTH+1);

   logic                          clk = 1'b0;
   logic                          rst;
   logic [CW-1:0]                 cfg_depth;
   logic                          s_valid;
   logic                          s_ready;
   logic [DATA_WIDTH-1:0]         s_data;
   logic                          fill_done;
   logic                          rd_avail;
   logic                          rd_bank;
   logic                          rd_release;
   logic [NUM_CH-1:0]             enb;
   logic [NUM_CH*AW-1:0]          addrb;
   logic [NUM_CH*DATA_WIDTH-1:0]  dob;
   logic [NUM_CH-1:0]             dob_valid;
   logic [1:0]                    full_cnt;

   weight_pingpong_buf #(.SRAM_DEPTH(SRAM_DEPTH), .NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH)) dut (
      .clk(clk), .rst(rst), .cfg_depth(cfg_depth), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .fill_done(fill_done), .rd_avail(rd_avail), .rd_bank(rd_bank),
      .rd_release(rd_release), .enb(enb), .addrb(addrb), .dob(dob), .dob_valid(dob_valid),
      .full_cnt(full_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: bank contents, FULL flags and bank pointers.
   logic [DATA_WIDTH-1:0]         exp_mem [2][NUM_CH][SRAM_DEPTH];
   int                            m_full [2];
   int                            m_wr, m_rd;
   logic [NUM_CH*DATA_WIDTH-1:0]  exp_dob;
   int                            checks = 0;
   int                            errors = 0;

   function automatic int eff(input int c);
      return (c == 0 || c > SRAM_DEPTH) ? SRAM_DEPTH : c;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_full_cnt"}, full_cnt, m_full[0] + m_full[1]);
      chk({tag, "_rd_avail"}, rd_avail, m_full[m_rd]);
      chk({tag, "_rd_bank"},  rd_bank,  m_rd);
   endtask

   task automatic set_addr(input int a);
      assert (a < SRAM_DEPTH) else $fatal(1, "FAIL addr_range observed=%0d required<%0d", a, SRAM_DEPTH);
      for (int c = 0; c < NUM_CH; c++) addrb[c*AW +: AW] = AW'(a);
   endtask

   task automatic rb(input int d, input string tag);
      for (int a = 0; a < d; a++) begin
         enb = '1;
         set_addr(a);
         @(negedge clk);
         for (int c = 0; c < NUM_CH; c++) exp_dob[c*DATA_WIDTH +: DATA_WIDTH] = exp_mem[m_rd][c][a];
         chk({tag, "_dob"}, dob, exp_dob);
         chk({tag, "_dob_valid"}, dob_valid, {NUM_CH{1'b1}});
      end
      enb = '0;
   endtask

   task automatic rel(input string tag);
      rd_release = 1'b1;
      @(negedge clk);
      rd_release = 1'b0;
      if (m_full[m_rd] != 0) begin
         m_full[m_rd] = 0;
         m_rd ^= 1;
      end
      check_state(tag);
   endtask

   // Streams one complete bank; beat k lands at channel k/d, address k%d.
   task automatic fill(input int gap_pct, input bit rnd, input int next_cfg, input bit rel_last,
                       input string tag);
      int d, total, k, guard, iters, ready_cyc, early;
      logic [DATA_WIDTH-1:0] v;
      d = eff(int'(cfg_depth));
      total = NUM_CH * d;
      k = 0; guard = 0; iters = 0; ready_cyc = 0; early = 0;
      s_valid = 1'b0;
      while (s_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, "_start_ready"}, s_ready, 1'b1);
      while (k < total && guard < 40000) begin
         guard++;
         iters++;
         if (fill_done === 1'b1) early = 1;
         if (s_ready === 1'b1) ready_cyc++;
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
         end else begin
            v = rnd ? 8'($urandom) : 8'(k);
            s_valid = 1'b1;
            s_data  = v;
            if (s_ready === 1'b1) begin
               exp_mem[m_wr][k / d][k % d] = v;
               k++;
               if (k == total) begin
                  cfg_depth  = CW'(next_cfg);
                  rd_release = rel_last;
               end
            end
         end
         @(negedge clk);
      end
      s_valid    = 1'b0;
      rd_release = 1'b0;
      chk({tag, "_beats"}, k, total);
      chk({tag, "_ready_cont"}, ready_cyc, iters);
      chk({tag, "_no_early_done"}, early, 0);
      if (rel_last && m_full[m_rd] != 0) begin
         m_full[m_rd] = 0;
         m_rd ^= 1;
      end
      m_full[m_wr] = 1;
      m_wr ^= 1;
      chk({tag, "_fill_done"}, fill_done, 1'b1);
      chk({tag, "_ready_drop"}, s_ready, 1'b0);
      check_state(tag);
      @(negedge clk);
      chk({tag, "_done_pulse"}, fill_done, 1'b0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; rd_release = 1'b0;
      enb = '0; addrb = '0; cfg_depth = CW'(4);
      m_full[0] = 0; m_full[1] = 0; m_wr = 0; m_rd = 0; exp_dob = '0;
      repeat (2) @(negedge clk);
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_fill_done", fill_done, 1'b0);
      chk("rst_dob", dob, '0);
      chk("rst_dob_valid", dob_valid, '0);
      check_state("rst");
      rst = 1'b0;

      // Fill 1: bank0, depth 4, value k at beat k, no stalls.
      fill(0, 1'b0, 4, 1'b0, "f1");
      enb = 16'h0020;
      set_addr(2);
      @(negedge clk);
      chk("f1_ch5_addr2", dob[5*DATA_WIDTH +: DATA_WIDTH], 8'd22);
      chk("f1_ch5_valid", dob_valid, 16'h0020);
      rb(4, "f1_rb");

      // Fill 2: bank1 while bank0 stays FULL.
      fill(0, 1'b1, 4, 1'b0, "f2");
      s_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_data = 8'($urandom);
         @(negedge clk);
         chk("bp_ready_low", s_ready, 1'b0);
      end
      s_valid = 1'b0;
      rb(1, "bp_rb_bank0");

      // Release bank0 with a read in the same cycle: the read sees bank0.
      enb = '1;
      set_addr(3);
      rd_release = 1'b1;
      @(negedge clk);
      rd_release = 1'b0;
      enb = '0;
      for (int c = 0; c < NUM_CH; c++) exp_dob[c*DATA_WIDTH +: DATA_WIDTH] = exp_mem[m_rd][c][3];
      chk("rel_read_dob", dob, exp_dob);
      chk("rel_read_valid", dob_valid, {NUM_CH{1'b1}});
      m_full[m_rd] = 0;
      m_rd ^= 1;
      check_state("rel1");

      // Fill 3 into bank0, releasing bank1 on the very last beat.
      fill(0, 1'b1, 50, 1'b1, "f3");
      rb(4, "f3_rb");

      // Fill 4: depth 50 with ~30% idle cycles on the stream.
      fill(30, 1'b1, 0, 1'b0, "f4");
      rel("rel4");
      rb(50, "f4_rb");

      // Fill 5: cfg_depth 0 means full depth.
      fill(10, 1'b1, 63, 1'b0, "f5");
      rel("rel5");
      rb(50, "f5_rb");

      // Fill 6: cfg_depth 63 clamps to full depth.
      fill(10, 1'b1, 4, 1'b0, "f6");
      rel("rel6");
      rb(50, "f6_rb");

      // Abandon a fill of bank0 with reset at beat 30.
      guard = 0;
      while (s_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("rstfill_ready", s_ready, 1'b1);
      for (int k = 0; k < 30; k++) begin
         s_valid = 1'b1;
         s_data  = 8'($urandom);
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      m_full[0] = 0; m_full[1] = 0; m_wr = 0; m_rd = 0;
      chk("midrst_s_ready", s_ready, 1'b0);
      chk("midrst_fill_done", fill_done, 1'b0);
      chk("midrst_dob", dob, '0);
      chk("midrst_dob_valid", dob_valid, '0);
      check_state("midrst");
      s_valid = 1'b0;
      cfg_depth = CW'(4);
      @(negedge clk);
      rst = 1'b0;
      fill(0, 1'b1, 4, 1'b0, "f7");
      rb(4, "f7_rb");

      // Reads while no bank is available: no valid, data held.
      rel("rel7");
      enb = '1;
      set_addr(0);
      @(negedge clk);
      chk("noavail_valid", dob_valid, '0);
      chk("noavail_dob_hold", dob, exp_dob);
      enb = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
